// File: rtl/commu_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : commu_regbank
//  Description : Bus-mapped register bank with key-locked configuration
//                registers, handshaked command channels with overflow
//                flags, sticky W1C status, and a registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module commu_regbank #(
  parameter int                   NUM_CFG   = 4,
  // Listed register 0 first: the leftmost byte resets cfg register 0.
  parameter logic [8*NUM_CFG-1:0] CFG_INIT  = {8'd20, 8'd0, 8'd0, 8'd0},
  parameter int                   NUM_CMD   = 2,
  parameter int                   UNLOCK_TO = 1024,
  parameter bit                   LOCK_EN   = 1'b1,
  parameter logic [7:0]           VERSION   = 8'h21
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic                   fx_wr,
  input  logic [15:0]            fx_waddr,
  input  logic [7:0]             fx_data,
  input  logic                   fx_rd,
  input  logic [15:0]            fx_raddr,
  output logic [7:0]             fx_q,
  input  logic [5:0]             mod_id,
  output logic [8*NUM_CFG-1:0]   cfg_out,
  output logic [NUM_CMD-1:0]     cmd_req,
  output logic [8*NUM_CMD-1:0]   cmd_data,
  input  logic [NUM_CMD-1:0]     cmd_ack,
  input  logic [7:0]             sts_in,
  output logic                   unlocked
);

  localparam int CW = $clog2(UNLOCK_TO);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    KEY1     = 2'd1,
    UNLOCKED = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_idle_cnt;
  logic [7:0]      r_sts;
  logic [7:0]      r_ovf;

  logic            w_wr_sel;
  logic            w_rd_sel;
  logic [7:0]      w_wr_off;
  logic [7:0]      w_rd_off;
  logic            w_key_wr;
  logic            w_key_abort;
  logic            w_wr;
  logic [7:0]      w_cfg_idx;
  logic            w_cfg_hit;
  logic [7:0]      w_cmd_idx;
  logic            w_cmd_hit;
  logic [NUM_CMD-1:0] w_cmd_wr;
  logic [7:0]      w_ovf_set;
  logic [7:0]      w_sts_clr;
  logic [7:0]      w_ovf_clr;
  logic [7:0]      w_rdata;
  logic            w_unused;

  // Address bits above the module select carry no meaning here.
  assign w_unused = ^{fx_waddr[15:14], fx_raddr[15:14]};

  assign w_wr_sel = fx_wr & (fx_waddr[13:8] == mod_id);
  assign w_rd_sel = fx_rd & (fx_raddr[13:8] == mod_id);
  assign w_wr_off = fx_waddr[7:0];
  assign w_rd_off = fx_raddr[7:0];

  // A selected write in KEY1 that is not the second key breaks the sequence
  // and is swallowed entirely, whatever offset it targets.
  assign w_key_wr    = w_wr_sel & (w_wr_off == 8'h02);
  assign w_key_abort = (r_state == KEY1) & w_wr_sel & ~(w_key_wr & (fx_data == 8'hA5));
  assign w_wr        = w_wr_sel & ~w_key_abort;

  assign w_cfg_idx = w_wr_off - 8'h10;
  assign w_cfg_hit = w_wr & unlocked & (w_wr_off >= 8'h10) & (w_cfg_idx < 8'(NUM_CFG));
  assign w_cmd_idx = w_wr_off - 8'h30;
  assign w_cmd_hit = w_wr & (w_wr_off >= 8'h30) & (w_cmd_idx < 8'(NUM_CMD));

  assign w_sts_clr = (w_wr && (w_wr_off == 8'h08)) ? fx_data : 8'h00;
  assign w_ovf_clr = (w_wr && (w_wr_off == 8'h09)) ? fx_data : 8'h00;

  // Per-channel command write strobes and overflow detection.
  always_comb begin
    w_cmd_wr  = '0;
    w_ovf_set = 8'h00;
    for (int k = 0; k < NUM_CMD; k++) begin
      w_cmd_wr[k]  = w_cmd_hit && (w_cmd_idx == 8'(k));
      w_ovf_set[k] = w_cmd_hit && (w_cmd_idx == 8'(k)) && cmd_req[k] && !cmd_ack[k];
    end
  end

  // Read data mux; sampled from current state so a same-cycle write is not seen.
  always_comb begin
    w_rdata = 8'h00;
    case (w_rd_off)
      8'h00: w_rdata = {2'b00, mod_id};
      8'h01: w_rdata = VERSION;
      8'h02: w_rdata = {6'b000000, r_state};
      8'h08: w_rdata = r_sts;
      8'h09: w_rdata = r_ovf;
      8'h0A: w_rdata[NUM_CMD-1:0] = cmd_req;
      default: begin
        for (int k = 0; k < NUM_CFG; k++) begin
          if (w_rd_off == 8'(8'h10 + k)) w_rdata = cfg_out[8*k +: 8];
        end
        for (int k = 0; k < NUM_CMD; k++) begin
          if (w_rd_off == 8'(8'h30 + k)) w_rdata = cmd_data[8*k +: 8];
        end
      end
    endcase
  end

  // Registered read port: returns zero in any cycle without a selected read.
  always_ff @(posedge clk_sys) begin
    if (rst) fx_q <= 8'h00;
    else     fx_q <= w_rd_sel ? w_rdata : 8'h00;
  end

  // Key sequence FSM with idle auto-relock; unlocked mirrors the next state.
  always_ff @(posedge clk_sys) begin
    if (rst || !LOCK_EN) begin
      r_state    <= LOCKED;
      r_idle_cnt <= '0;
      unlocked   <= ~LOCK_EN;
    end else begin
      case (r_state)
        LOCKED: begin
          if (w_key_wr && (fx_data == 8'h5A)) r_state <= KEY1;
        end
        KEY1: begin
          if (w_wr_sel) begin
            if (w_key_wr && (fx_data == 8'hA5)) begin
              r_state    <= UNLOCKED;
              r_idle_cnt <= '0;
              unlocked   <= 1'b1;
            end else begin
              r_state <= LOCKED;
            end
          end
        end
        UNLOCKED: begin
          if (w_wr_sel) begin
            r_idle_cnt <= '0;
            if (w_key_wr) begin
              r_state  <= LOCKED;
              unlocked <= 1'b0;
            end
          end else if (r_idle_cnt == CW'(UNLOCK_TO - 1)) begin
            r_state    <= LOCKED;
            r_idle_cnt <= '0;
            unlocked   <= 1'b0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= LOCKED;
          r_idle_cnt <= '0;
          unlocked   <= 1'b0;
        end
      endcase
    end
  end

  // Configuration registers, writable only while unlocked.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int k = 0; k < NUM_CFG; k++)
        cfg_out[8*k +: 8] <= CFG_INIT[8*(NUM_CFG-1-k) +: 8];
    end else begin
      for (int k = 0; k < NUM_CFG; k++)
        if (w_cfg_hit && (w_cfg_idx == 8'(k))) cfg_out[8*k +: 8] <= fx_data;
    end
  end

  // Command channels: a write is accepted when idle or when acked this cycle.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cmd_req  <= '0;
      cmd_data <= '0;
    end else begin
      for (int k = 0; k < NUM_CMD; k++) begin
        if (w_cmd_wr[k] && (!cmd_req[k] || cmd_ack[k])) begin
          cmd_data[8*k +: 8] <= fx_data;
          cmd_req[k]         <= 1'b1;
        end else if (cmd_ack[k]) begin
          cmd_req[k] <= 1'b0;
        end
      end
    end
  end

  // Sticky status and overflow flags; a new event beats a same-cycle clear.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      r_sts <= 8'h00;
      r_ovf <= 8'h00;
    end else begin
      r_sts <= (r_sts & ~w_sts_clr) | sts_in;
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_ovf_set;
    end
  end

endmodule
`default_nettype wire

// File: doc/commu_regbank.md
COMMU_REGBANK -- requirements
Module: commu_regbank

Interface
REQ-001 SHALL have parameter NUM_CFG, default 4, number of lockable config registers (1..32).
REQ-002 SHALL have parameter CFG_INIT, default {8'd20,8'd0,8'd0,8'd0}, packed reset values; byte i resets cfg register i.
REQ-003 SHALL have parameter NUM_CMD, default 2, number of command channels (1..8).
REQ-004 SHALL have parameter UNLOCK_TO, default 1024, idle cycles before auto-relock (>=2).
REQ-005 SHALL have parameter LOCK_EN, default 1; 0 = always unlocked, KEY FSM inert.
REQ-006 SHALL have parameter VERSION, default 8'h21, value returned at offset 0x01.
REQ-007 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 fx_wr  in  1  bus write strobe, one cycle per write.
REQ-010 fx_waddr  in  16  write address; [13:8] module select, [7:0] offset.
REQ-011 fx_data  in  8  write data.
REQ-012 fx_rd  in  1  bus read strobe.
REQ-013 fx_raddr  in  16  read address, same split as fx_waddr.
REQ-014 fx_q  out  8  registered read data.
REQ-015 mod_id  in  6  module identifier.
REQ-016 cfg_out  out  8*NUM_CFG  config register contents, byte i = register i.
REQ-017 cmd_req  out  NUM_CMD  per-channel command pending, level.
REQ-018 cmd_data  out  8*NUM_CMD  per-channel command payload.
REQ-019 cmd_ack  in  NUM_CMD  per-channel consumer acknowledge, one-cycle pulse.
REQ-020 sts_in  in  8  event pulses into sticky status.
REQ-021 unlocked  out  1  high while config writes are permitted.

Function
REQ-022 Write select SHALL be fx_wr & (fx_waddr[13:8]==mod_id); read select SHALL be fx_rd & (fx_raddr[13:8]==mod_id).
REQ-023 Map: 0x00 RO {2'b0,mod_id}; 0x01 RO VERSION; 0x02 KEY; 0x08 STS W1C; 0x09 OVF W1C; 0x0A RO cmd_req zero-extended; 0x10+i CFG i; 0x30+i CMD i; all other offsets read 0, writes ignored.
REQ-024 Reads: fx_q SHALL present data 1 cycle after a selected fx_rd and SHALL be 0 in every cycle after an unselected or absent read.
REQ-025 A read and write to the same offset in one cycle SHALL return the pre-write value.
REQ-026 KEY FSM states LOCKED(0), KEY1(1), UNLOCKED(2); reading 0x02 SHALL return the state code.
REQ-027 LOCKED -> KEY1 on a write of 8'h5A to 0x02; other writes leave it LOCKED.
REQ-028 KEY1 -> UNLOCKED on a write of 8'hA5 to 0x02; any other selected write SHALL return it to LOCKED and not be applied.
REQ-029 UNLOCKED -> LOCKED on any write to 0x02, or when the idle counter reaches UNLOCK_TO-1.
REQ-030 Idle counter SHALL clear on entry to UNLOCKED and on every selected write; it SHALL increment each other cycle while UNLOCKED.
REQ-031 unlocked SHALL equal (state==UNLOCKED) | ~LOCK_EN, registered.
REQ-032 CFG writes SHALL take effect only when unlocked is high; otherwise they are dropped silently.
REQ-033 CMD i write when cmd_req[i]=0: cmd_data[i] <= fx_data, cmd_req[i] <= 1 next cycle; not lock-gated.
REQ-034 cmd_ack[i] SHALL clear cmd_req[i]; ack and write in the same cycle SHALL accept the new command (req stays 1, data updated).
REQ-035 CMD i write while cmd_req[i]=1 without ack SHALL be dropped and set OVF[i].
REQ-036 STS[b] SHALL set on sts_in[b]; writing 1 to STS[b] or OVF[b] SHALL clear it; set SHALL win over a same-cycle clear.
REQ-037 cmd_ack on an idle channel SHALL be ignored.

Reset
REQ-038 On rst: fx_q=0, cfg_out=CFG_INIT, cmd_req=0, cmd_data=0, STS=0, OVF=0, FSM=LOCKED, idle counter=0, unlocked=~LOCK_EN.
REQ-039 rst asserted mid-sequence SHALL abandon KEY1/UNLOCKED and any pending command with no residual effect.

Verification
REQ-040 mod_id=5, read 0x0500/0x0501 -> fx_q 8'h05 then 8'h21, each 1 cycle after fx_rd; next cycle fx_q=0.
REQ-041 Write 0x0510=8'h33 while LOCKED -> cfg_out byte0 stays 20; write 0x5A, 0xA5 to 0x0502, then 0x33 -> byte0=8'h33, unlocked=1.
REQ-042 Write 0x5A, then 0x0511=8'h01, then 0xA5 -> FSM LOCKED after second write, cfg unchanged, unlocked=0.
REQ-043 Unlock, idle UNLOCK_TO cycles -> unlocked drops; read 0x0502 returns 0.
REQ-044 Write CMD0=8'h44, write CMD0=8'h55 before ack -> cmd_data0=8'h44, OVF=8'h01; ack -> cmd_req0=0; write 1 to 0x09 -> OVF=0.
REQ-045 sts_in=8'h04 same cycle as write 8'h04 to 0x08 -> STS reads 8'h04; later W1C alone -> 8'h00.
